// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: phase encodings,
// direction levels and the up-sequence successor function.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Successor of a phase when rotating up: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One quadrature channel: multi-flop synchroniser followed by a run-length
// glitch filter. The filtered output only follows the synchronised input after
// it has differed for FILT_LEN consecutive cycles.
module quad_glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign dout     = filt_q;

    // Synchroniser shift chain; bit 0 is the metastability-exposed stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive disagreeing cycles; adopt the new value on the last one.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_out != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync_out;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: filters phase A/B, then decodes Gray transitions
// into a one-cycle step pulse plus a direction level, with a sticky error for
// double-bit jumps.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       qa,
    input  logic       qb,
    input  logic       err_clr,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic [1:0] phase
);

    logic       filt_a, filt_b;
    logic [1:0] filt;
    logic [1:0] diff;
    logic       illegal;

    logic [1:0] phase_q, phase_d;
    logic       step_q, step_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_a (
        .clk (clk),
        .rst (rst),
        .din (qa),
        .dout(filt_a)
    );

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt_b (
        .clk (clk),
        .rst (rst),
        .din (qb),
        .dout(filt_b)
    );

    assign filt    = {filt_a, filt_b};
    assign diff    = filt ^ phase_q;
    assign illegal = &diff;

    // Decode the filtered transition; phase always tracks so decode resyncs.
    always_comb begin
        phase_d = filt;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = err_q;
        if (en && (diff != 2'b00) && !illegal) begin
            step_d = 1'b1;
            dir_d  = (filt == next_up(phase_q)) ? DIR_UP : DIR_DN;
        end
        // Set beats clear when both happen in the same cycle.
        if (en && illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Decode output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_00;
            step_q  <= 1'b0;
            dir_q   <= DIR_UP;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign phase = phase_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign err   = err_q;

endmodule
